// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instructions, holds them for the datapath, and sequences the PC.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic [5:0]         op_code,
    input  logic [9:0]         ctrl_word,
    input  logic               alu_zero,
    input  logic               ex_done,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [COUNT_W-1:0] retired
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
    state_t state, state_d;
    logic [31:0] pc_d, instr_d, pc_plus4, br_off, next_pc;
    logic [COUNT_W-1:0] retired_d;
    logic valid_d, req_d, ctrl_unused;
    assign ctrl_unused = ^{ctrl_word[8:3], ctrl_word[1:0]};
    assign imem_addr = pc;
    assign op_code = instr[31:26];
    assign pc_plus4 = pc + 32'd4;
    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign next_pc = ctrl_word[9] ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                     (ctrl_word[2] && alu_zero) ? pc_plus4 + br_off : pc_plus4;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            retired     <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            instr       <= instr_d;
            instr_valid <= valid_d;
            imem_req    <= req_d;
            retired     <= retired_d;
        end
    end
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        instr_d   = instr;
        valid_d   = instr_valid;
        req_d     = imem_req;
        retired_d = retired;
        case (state)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: if (imem_ready) begin
                state_d = ISSUE;
                instr_d = imem_rdata;
                valid_d = 1'b1;
                req_d   = 1'b0;
            end
            ISSUE: if (ex_done) begin
                state_d   = FETCH;
                pc_d      = next_pc;
                valid_d   = 1'b0;
                req_d     = 1'b1;
                retired_d = retired + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random and directed stimulus checked against a transaction-level model.
module tb_fetch_sequencer;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        imem_req, imem_ready = 1'b0, alu_zero = 1'b0, ex_done = 1'b0, instr_valid;
    logic [31:0] imem_addr, imem_rdata = '0, instr, pc;
    logic [5:0]  op_code;
    logic [9:0]  ctrl_word = '0;
    logic [3:0]  retired;
    int checks = 0, errors = 0;
    logic [31:0] m_pc, m_instr;
    logic [3:0]  m_ret;
    logic        m_valid, m_req, m_started;

    fetch_sequencer #(.RESET_PC(32'h0), .COUNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .op_code(op_code),
        .ctrl_word(ctrl_word), .alu_zero(alu_zero), .ex_done(ex_done), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = '0; m_ret = '0; m_valid = 1'b0; m_req = 1'b0; m_started = 1'b0;
    endtask

    task automatic check_all();
        check("pc", pc, m_pc);
        check("retired", {28'b0, retired}, {28'b0, m_ret});
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        check("instr", instr, m_instr);
        check("imem_addr", imem_addr, m_pc);
        check("op_code", {26'b0, op_code}, {26'b0, m_instr[31:26]});
    endtask

    function automatic logic [31:0] target(input logic [9:0] cw, input logic z);
        int off;
        if (cw[9]) return ((m_pc + 32'd4) & 32'hF000_0000) | ({6'b0, m_instr[25:0]} << 2);
        if (cw[2] && z) begin
            off = $signed(m_instr[15:0]);
            return m_pc + 32'd4 + 32'(off * 4);
        end
        return m_pc + 32'd4;
    endfunction

    task automatic step(input logic rdy, input logic [31:0] rd, input logic ex,
                        input logic [9:0] cw, input logic z);
        imem_ready = rdy; imem_rdata = rd; ex_done = ex; ctrl_word = cw; alu_zero = z;
        @(posedge clk);
        if (!m_started) begin
            m_started = 1'b1; m_req = 1'b1;
        end else if (!m_valid) begin
            if (rdy) begin m_instr = rd; m_valid = 1'b1; m_req = 1'b0; end
        end else if (ex) begin
            m_pc = target(cw, z); m_valid = 1'b0; m_ret = m_ret + 4'd1; m_req = 1'b1;
        end
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [31:0] rd, input logic [9:0] cw, input logic z, input int waits);
        repeat (waits) step(1'b0, $urandom, 1'b0, 10'h0, 1'b0);
        step(1'b1, rd, 1'b0, 10'h0, 1'b0);
        step(1'b0, $urandom, 1'b1, cw, z);
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all();
        @(negedge clk) rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 10'h0, 1'b0);
        run_instr(32'h012A4020, 10'b0000000000, 1'b0, 2);
        check("seq_pc", pc, 32'h4);
        check("seq_addr", imem_addr, 32'h4);
        run_instr(32'h08000040, 10'b1000000000, 1'b0, 1);
        check("jump_to_100", pc, 32'h100);
        run_instr(32'h08000010, 10'b1000000000, 1'b0, 0);
        check("jump_to_40", pc, 32'h40);
        run_instr(32'h08000008, 10'b1000000101, 1'b1, 0);
        check("jump_priority", pc, 32'h20);
        run_instr(32'h1109FFFE, 10'b0000000101, 1'b1, 0);
        check("branch_taken", pc, 32'h1C);
        run_instr(32'h08000008, 10'b1000000000, 1'b0, 0);
        run_instr(32'h1109FFFE, 10'b0000000101, 1'b0, 1);
        check("branch_not_taken", pc, 32'h24);
        step(1'b0, 32'h0, 1'b1, 10'b0000000000, 1'b0);
        check("ex_in_fetch_pc", pc, 32'h24);
        step(1'b1, 32'h08000000, 1'b0, 10'h0, 1'b0);
        step(1'b1, 32'hDEADBEEF, 1'b0, 10'h0, 1'b0);
        check("ready_in_issue", instr, 32'h08000000);
        step(1'b0, 32'h0, 1'b1, 10'b1000000000, 1'b0);
        run_instr(32'h1109FFFE, 10'b0000000101, 1'b1, 0);
        check("branch_wrap", pc, 32'hFFFF_FFFC);
        run_instr(32'h8C880004, 10'b0011110000, 1'b0, 0);
        check("pc_wrap", pc, 32'h0);
        for (int i = 0; i < 3000; i++)
            step(1'($urandom), $urandom, 1'($urandom), 10'($urandom), 1'($urandom));
        for (int i = 0; i < 4 && !(m_started && !m_valid); i++)
            step(1'b0, $urandom, 1'b1, 10'($urandom), 1'($urandom));
        check("pre_reset_req", {31'b0, imem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", {31'b0, imem_req}, 32'h0);
        check("async_pc", pc, 32'h0);
        check("async_valid", {31'b0, instr_valid}, 32'h0);
        check("async_retired", {28'b0, retired}, 32'h0);
        imem_ready = 1'b1; imem_rdata = 32'h12345678;
        @(posedge clk) #1;
        check("ready_in_reset", {31'b0, instr_valid}, 32'h0);
        check("instr_in_reset", instr, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        step(1'b0, 32'h0, 1'b0, 10'h0, 1'b0);
        check("restart_addr", imem_addr, 32'h0);
        run_instr(32'h012A4020, 10'b0000000000, 1'b0, 1);
        check("restart_pc", pc, 32'h4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
